// File: rtl/uart_tx_cfg.sv
// Configurable UART serializer: start, 5..DATA_W data bits LSB first, optional parity, 1/1.5/2 stop, line break.
// Latency: START drives the line one clock after i_tx_start is seen in IDLE; each bit lasts OVS baud ticks.
// Backpressure: i_tx_start is level-sensitive and sampled only in IDLE; o_tx_done_tick pops the source FIFO.
module uart_tx_cfg #(
    parameter int DATA_W   = 8,
    parameter int OVS      = 16,
    parameter int BRK_BITS = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_baud_tick,
    input  logic              i_tx_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic [3:0]        i_data_len,
    input  logic [1:0]        i_par,
    input  logic [1:0]        i_stop_num,
    input  logic              i_break,
    output logic              o_tx,
    output logic              o_tx_done_tick,
    output logic              o_busy
);

    localparam int S_W     = $clog2(2 * OVS);
    localparam int BRK_MAX = BRK_BITS * OVS;
    localparam int B_W     = $clog2(BRK_MAX + 1);
    localparam logic [3:0] LEN_MIN = 4'd5;
    localparam logic [3:0] LEN_MAX = 4'(DATA_W);
    localparam logic [S_W-1:0] BIT_LAST = S_W'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK, BRKMARK
    } state_t;

    state_t            state_q, state_n;
    logic [S_W-1:0]    s_q, s_n;
    logic [3:0]        n_q, n_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [3:0]        len_q, len_n;
    logic [1:0]        par_q, par_n;
    logic [1:0]        stop_q, stop_n;
    logic              pbit_q, pbit_n;
    logic [B_W-1:0]    brk_q, brk_n;
    logic              tx_q, tx_n;
    logic              busy_q;
    logic              done;

    logic [3:0]        len_clamp;
    logic              par_acc;
    logic              par_calc;
    logic [S_W-1:0]    sb_last;

    always_comb begin
        len_clamp = i_data_len;
        if (i_data_len < LEN_MIN)
            len_clamp = LEN_MIN;
        else if (i_data_len > LEN_MAX)
            len_clamp = LEN_MAX;
    end

    // Parity covers only the bits that will actually be sent.
    always_comb begin
        par_acc = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (i < int'(len_clamp))
                par_acc ^= i_data[i];
    end

    always_comb begin
        case (i_par)
            2'b01:   par_calc = par_acc;
            2'b10:   par_calc = ~par_acc;
            2'b11:   par_calc = 1'b1;
            default: par_calc = 1'b0;
        endcase
    end

    always_comb begin
        case (stop_q)
            2'b00:   sb_last = S_W'(OVS - 1);
            2'b01:   sb_last = S_W'((3 * OVS) / 2 - 1);
            default: sb_last = S_W'(2 * OVS - 1);
        endcase
    end

    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        n_n     = n_q;
        shift_n = shift_q;
        len_n   = len_q;
        par_n   = par_q;
        stop_n  = stop_q;
        pbit_n  = pbit_q;
        brk_n   = brk_q;
        done    = 1'b0;
        tx_n    = 1'b1;

        case (state_q)
            IDLE: begin
                if (i_break) begin
                    state_n = BREAK;
                    s_n     = '0;
                    brk_n   = '0;
                end else if (i_tx_start) begin
                    state_n = START;
                    s_n     = '0;
                    shift_n = i_data;
                    len_n   = len_clamp;
                    par_n   = i_par;
                    stop_n  = i_stop_num;
                    pbit_n  = par_calc;
                end
            end
            START: begin
                if (i_baud_tick) begin
                    if (s_q == BIT_LAST) begin
                        state_n = DATA;
                        s_n     = '0;
                        n_n     = '0;
                    end else begin
                        s_n = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (i_baud_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_n     = '0;
                        shift_n = shift_q >> 1;
                        if (n_q == len_q - 4'd1)
                            state_n = (par_q != 2'b00) ? PARITY : STOP;
                        else
                            n_n = n_q + 4'd1;
                    end else begin
                        s_n = s_q + S_W'(1);
                    end
                end
            end
            PARITY: begin
                if (i_baud_tick) begin
                    if (s_q == BIT_LAST) begin
                        state_n = STOP;
                        s_n     = '0;
                    end else begin
                        s_n = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (i_baud_tick) begin
                    if (s_q == sb_last) begin
                        state_n = IDLE;
                        s_n     = '0;
                        done    = 1'b1;
                    end else begin
                        s_n = s_q + S_W'(1);
                    end
                end
            end
            BREAK: begin
                // Count saturates so an arbitrarily long request holds the line low.
                if (i_baud_tick && brk_q != B_W'(BRK_MAX))
                    brk_n = brk_q + B_W'(1);
                if (brk_q == B_W'(BRK_MAX) && !i_break) begin
                    state_n = BRKMARK;
                    s_n     = '0;
                end
            end
            BRKMARK: begin
                if (i_baud_tick) begin
                    if (s_q == BIT_LAST) begin
                        state_n = IDLE;
                        s_n     = '0;
                    end else begin
                        s_n = s_q + S_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level follows the state being entered, so o_tx is a clean register.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = pbit_n;
            BREAK:   tx_n = 1'b0;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            len_q   <= '0;
            par_q   <= '0;
            stop_q  <= '0;
            pbit_q  <= 1'b0;
            brk_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            s_q     <= s_n;
            n_q     <= n_n;
            shift_q <= shift_n;
            len_q   <= len_n;
            par_q   <= par_n;
            stop_q  <= stop_n;
            pbit_q  <= pbit_n;
            brk_q   <= brk_n;
            tx_q    <= tx_n;
            busy_q  <= (state_n != IDLE);
        end
    end

    assign o_tx           = tx_q;
    assign o_busy         = busy_q;
    assign o_tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized and directed bench for uart_tx_cfg against a per-tick line-level reference model.
module tb_uart_tx_cfg;

    localparam int DATA_W   = 8;
    localparam int OVS      = 16;
    localparam int BRK_BITS = 11;
    localparam int DIV      = 3;

    logic              i_clk;
    logic              i_reset;
    logic              i_baud_tick;
    logic              i_tx_start;
    logic [DATA_W-1:0] i_data;
    logic [3:0]        i_data_len;
    logic [1:0]        i_par;
    logic [1:0]        i_stop_num;
    logic              i_break;
    logic              o_tx;
    logic              o_tx_done_tick;
    logic              o_busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DATA_W-1:0] fifo[$];
    bit                exp_q[$];

    uart_tx_cfg #(.DATA_W(DATA_W), .OVS(OVS), .BRK_BITS(BRK_BITS)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_baud_tick    (i_baud_tick),
        .i_tx_start     (i_tx_start),
        .i_data         (i_data),
        .i_data_len     (i_data_len),
        .i_par          (i_par),
        .i_stop_num     (i_stop_num),
        .i_break        (i_break),
        .o_tx           (o_tx),
        .o_tx_done_tick (o_tx_done_tick),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        i_baud_tick = 1'b0;
        forever begin
            repeat (DIV - 1) @(posedge i_clk);
            #1 i_baud_tick = 1'b1;
            @(posedge i_clk);
            #1 i_baud_tick = 1'b0;
        end
    end

    // Source FIFO: pops on the done pulse, so the next word shows one clock later.
    initial begin
        logic pop;
        i_tx_start = 1'b0;
        i_data     = '0;
        forever begin
            @(negedge i_clk);
            pop = o_tx_done_tick;
            @(posedge i_clk);
            #1;
            if (i_reset)
                fifo.delete();
            else if (pop && fifo.size() > 0)
                void'(fifo.pop_front());
            i_tx_start = (fifo.size() != 0);
            i_data     = (fifo.size() != 0) ? fifo[0] : '0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for every baud tick of one frame.
    task automatic build_exp(input logic [DATA_W-1:0] d, input int len_raw, input int par, input int stop);
        int len;
        int ones;
        int sb;
        bit pb;
        len  = (len_raw < 5) ? 5 : ((len_raw > DATA_W) ? DATA_W : len_raw);
        ones = 0;
        exp_q.delete();
        repeat (OVS) exp_q.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            repeat (OVS) exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par != 0) begin
            pb = (par == 1) ? bit'(ones % 2) : ((par == 2) ? bit'(1 - ones % 2) : 1'b1);
            repeat (OVS) exp_q.push_back(pb);
        end
        sb = (stop == 0) ? OVS : ((stop == 1) ? (3 * OVS) / 2 : 2 * OVS);
        repeat (sb) exp_q.push_back(1'b1);
    endtask

    task automatic run_frame(input string tag, input bit expect_done,
                             output int start_cyc, output int done_cyc);
        bit seen;
        int k;
        seen      = 1'b0;
        done_cyc  = -1;
        start_cyc = -1;
        for (int w = 0; w < 200 && !seen; w++) begin
            @(negedge i_clk);
            if (o_tx === 1'b0) seen = 1'b1;
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        if (!seen) return;
        start_cyc = cyc;
        k = 0;
        forever begin
            if (i_baud_tick) begin
                check($sformatf("%s_tx%0d", tag, k), 32'(o_tx), 32'(exp_q[k]));
                check($sformatf("%s_busy%0d", tag, k), 32'(o_busy), 32'd1);
                check($sformatf("%s_done%0d", tag, k), 32'(o_tx_done_tick),
                      32'(expect_done && k == exp_q.size() - 1));
                if (k == exp_q.size() - 1) done_cyc = cyc;
                k++;
            end else begin
                check({tag, "_done_off"}, 32'(o_tx_done_tick), 32'd0);
            end
            if (k == exp_q.size()) break;
            @(negedge i_clk);
        end
        @(negedge i_clk);
        check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_idle_tx"}, 32'(o_tx), 32'd1);
    endtask

    task automatic set_cfg(input int len, input int par, input int stop);
        i_data_len = 4'(len);
        i_par      = 2'(par);
        i_stop_num = 2'(stop);
    endtask

    initial begin
        int s1, d1, s2, d2;
        logic [DATA_W-1:0] w0, w1;
        int len, par, stop;

        i_reset = 1'b1;
        i_break = 1'b0;
        set_cfg(8, 0, 0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_tx_done_tick), 32'd0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        repeat (4) @(negedge i_clk);

        // 8N1 0xA5
        set_cfg(8, 0, 0);
        fifo.push_back(8'hA5);
        build_exp(8'hA5, 8, 0, 0);
        check("t1_len", 32'(exp_q.size()), 32'd160);
        run_frame("t1", 1'b1, s1, d1);

        // 7 bits even parity, 1.5 stop
        set_cfg(7, 1, 1);
        fifo.push_back(8'h02);
        build_exp(8'h02, 7, 1, 1);
        check("t2_len", 32'(exp_q.size()), 32'd168);
        run_frame("t2", 1'b1, s1, d1);

        // 6 bits odd parity, 2 stop, upper bits must not matter
        set_cfg(6, 2, 2);
        fifo.push_back(8'hC4);
        fifo.push_back(8'h04);
        build_exp(8'hC4, 6, 2, 2);
        run_frame("t3a", 1'b1, s1, d1);
        build_exp(8'h04, 6, 2, 2);
        run_frame("t3b", 1'b1, s2, d2);
        check("t3_gap", 32'(s2 - d1), 32'd2);

        // 5 bits mark parity, back-to-back
        set_cfg(5, 3, 0);
        w0 = DATA_W'($urandom);
        w1 = DATA_W'($urandom);
        fifo.push_back(w0);
        fifo.push_back(w1);
        build_exp(w0, 5, 3, 0);
        run_frame("t4a", 1'b1, s1, d1);
        build_exp(w1, 5, 3, 0);
        run_frame("t4b", 1'b1, s2, d2);
        check("t4_gap", 32'(s2 - d1), 32'd2);
        repeat (3) @(negedge i_clk);
        check("t4_fifo_empty", 32'(fifo.size()), 32'd0);

        // Config change mid-frame only affects the next frame
        set_cfg(8, 1, 0);
        w0 = DATA_W'($urandom);
        w1 = DATA_W'($urandom);
        fifo.push_back(w0);
        fifo.push_back(w1);
        build_exp(w0, 8, 1, 0);
        fork
            run_frame("t5a", 1'b1, s1, d1);
            begin
                repeat (20 * DIV) @(negedge i_clk);
                set_cfg(5, 2, 2);
            end
        join
        build_exp(w1, 5, 2, 2);
        run_frame("t5b", 1'b1, s2, d2);
        check("t5_gap", 32'(s2 - d1), 32'd2);

        // Short break request still yields the full minimum break plus one mark bit
        exp_q.delete();
        repeat (BRK_BITS * OVS) exp_q.push_back(1'b0);
        repeat (OVS) exp_q.push_back(1'b1);
        fork
            run_frame("t6", 1'b0, s1, d1);
            begin
                i_break = 1'b1;
                for (int t = 0; t < 3; ) begin
                    @(negedge i_clk);
                    if (i_baud_tick) t++;
                end
                i_break = 1'b0;
            end
        join

        // Randomized single frames, including out-of-range lengths
        for (int r = 0; r < 10; r++) begin
            len  = int'($urandom_range(0, 15));
            par  = int'($urandom_range(0, 3));
            stop = int'($urandom_range(0, 3));
            w0   = DATA_W'($urandom);
            set_cfg(len, par, stop);
            fifo.push_back(w0);
            build_exp(w0, len, par, stop);
            run_frame($sformatf("rnd%0d", r), 1'b1, s1, d1);
        end

        // Reset in the middle of the data phase aborts at once
        set_cfg(8, 0, 0);
        fifo.push_back(8'h00);
        begin
            bit seen;
            seen = 1'b0;
            for (int w = 0; w < 200 && !seen; w++) begin
                @(negedge i_clk);
                if (o_tx === 1'b0) seen = 1'b1;
            end
            check("rst_mid_start", 32'(seen), 32'd1);
        end
        repeat (40 * DIV) @(negedge i_clk);
        check("rst_mid_busy_pre", 32'(o_busy), 32'd1);
        check("rst_mid_tx_pre", 32'(o_tx), 32'd0);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        #1;
        check("rst_mid_tx", 32'(o_tx), 32'd1);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_done", 32'(o_tx_done_tick), 32'd0);
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        repeat (10) @(negedge i_clk);
        check("rst_post_busy", 32'(o_busy), 32'd0);
        check("rst_post_tx", 32'(o_tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
